// File: rtl/ram_io_responder.sv
// Memory-side responder for the byte-wide controller bus. It holds the main RAM and
// decodes an I/O window with a TX FIFO, an RX input port, a FIFO-level port and a halt port.
module ram_io_responder #(
   parameter int ADDR_WIDTH = 17,
   parameter int FIFO_DEPTH = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rdy,
   input  logic [31:0] mem_addr,
   input  logic [7:0]  mem_dout,
   input  logic        mem_rw,
   output logic [7:0]  mem_din,
   output logic        io_buffer_full,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic        rx_ready,
   output logic        io_overflow,
   output logic        sim_halt
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL_LVL      = CNT_W'(FIFO_DEPTH);
   localparam logic [CNT_W-1:0] NEAR_FULL_LVL = CNT_W'(FIFO_DEPTH - 2);

   typedef enum logic [2:0] {
      ACC_RAM_RD,
      ACC_RAM_WR,
      ACC_A_RD,
      ACC_A_WR,
      ACC_B_RD,
      ACC_B_WR,
      ACC_IO_RD,
      ACC_IO_WR
   } access_e;

   access_e               access;
   logic [7:0]            ram [2**ADDR_WIDTH];
   logic [7:0]            fifo_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]      wr_ptr;
   logic [PTR_W-1:0]      rd_ptr;
   logic [CNT_W-1:0]      count;
   logic                  prev_a_rd;
   logic [ADDR_WIDTH-1:0] idx;
   logic                  io_sel;
   logic                  first_a_rd;
   logic                  push_req;
   logic                  push;
   logic                  pop;
   logic                  ram_we;
   logic                  unused_addr_bits;

   assign idx              = mem_addr[ADDR_WIDTH-1:0];
   assign unused_addr_bits = ^mem_addr[31:18];

   // NOTE: combinational decode uses blocking assignments with a default first, so no latch is inferred.
   always_comb begin
      io_sel = (mem_addr[17:16] == 2'b11);
      access = mem_rw ? ACC_RAM_WR : ACC_RAM_RD;
      if (io_sel) begin
         if (mem_addr[2:0] == 3'd0)
            access = mem_rw ? ACC_A_WR : ACC_A_RD;
         else if (mem_addr[2:0] == 3'd4)
            access = mem_rw ? ACC_B_WR : ACC_B_RD;
         else
            access = mem_rw ? ACC_IO_WR : ACC_IO_RD;
      end
   end

   assign tx_valid       = (count != '0);
   assign tx_data        = fifo_mem[rd_ptr];
   assign io_buffer_full = (count >= NEAR_FULL_LVL);
   assign pop            = tx_valid && tx_ready;
   assign push_req       = rdy && (access == ACC_A_WR);
   // A full FIFO still accepts a byte when the head leaves in the same cycle.
   assign push           = push_req && ((count != FULL_LVL) || pop);
   assign first_a_rd     = rdy && (access == ACC_A_RD) && !prev_a_rd;
   assign rx_ready       = first_a_rd && rx_valid;
   assign ram_we         = rst && rdy && (access == ACC_RAM_WR);

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mem_din     <= 8'h00;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         count       <= '0;
         prev_a_rd   <= 1'b0;
         io_overflow <= 1'b0;
         sim_halt    <= 1'b0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)
            rd_ptr <= rd_ptr + PTR_W'(1);
         if (push && !pop)
            count <= count + CNT_W'(1);
         else if (pop && !push)
            count <= count - CNT_W'(1);
         if (push_req && !push)
            io_overflow <= 1'b1;
         if (rdy && (access == ACC_B_WR))
            sim_halt <= 1'b1;
         if (rdy) begin
            prev_a_rd <= (access == ACC_A_RD);
            case (access)
               ACC_RAM_RD: mem_din <= ram[idx];
               ACC_A_RD:   if (!prev_a_rd) mem_din <= rx_valid ? rx_data : 8'h00;
               ACC_B_RD:   mem_din <= 8'(count);
               ACC_IO_RD:  mem_din <= 8'h00;
               default:    ;
            endcase
         end
      end
   end

   // NOTE: storage arrays have no reset; the pointers and count alone define which entries are valid.
   always_ff @(posedge clk) begin
      if (ram_we)
         ram[idx] <= mem_dout;
      if (push)
         fifo_mem[wr_ptr] <= mem_dout;
   end

endmodule

// File: tb/tb_ram_io_responder.sv
// Randomized bench for ram_io_responder, checked against a queue/associative-array
// model of the bus, FIFO and RX rules.
module tb_ram_io_responder;

   localparam int          FIFO_DEPTH = 8;
   localparam logic [31:0] IO_A = 32'h0003_0000;
   localparam logic [31:0] IO_B = 32'h0003_0004;

   logic        clk = 1'b0;
   logic        rst;
   logic        rdy;
   logic [31:0] mem_addr;
   logic [7:0]  mem_dout;
   logic        mem_rw;
   logic [7:0]  mem_din;
   logic        io_buffer_full;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        rx_ready;
   logic        io_overflow;
   logic        sim_halt;

   always #5 clk = ~clk;

   ram_io_responder #(.ADDR_WIDTH(17), .FIFO_DEPTH(FIFO_DEPTH)) dut (
      .clk(clk), .rst(rst), .rdy(rdy), .mem_addr(mem_addr), .mem_dout(mem_dout),
      .mem_rw(mem_rw), .mem_din(mem_din), .io_buffer_full(io_buffer_full),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
      .io_overflow(io_overflow), .sim_halt(sim_halt)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model state
   logic [7:0] ram_m [int];
   logic [7:0] fifo_q [$];
   logic [7:0] exp_din;
   logic       exp_ovf, exp_halt, last_a_read;
   // Pre-edge observations and expectations of the most recent bus cycle
   logic       obs_rx_ready, exp_rx_ready, obs_tx_valid, exp_tx_valid, obs_full, exp_full;
   logic [7:0] obs_tx_data, exp_tx_data;

   function automatic void model_reset();
      fifo_q.delete();
      exp_din     = 8'h00;
      exp_ovf     = 1'b0;
      exp_halt    = 1'b0;
      last_a_read = 1'b0;
   endfunction

   function automatic void model_step();
      int   idx       = int'(mem_addr[16:0]);
      logic io        = (mem_addr[17:16] == 2'b11);
      logic is_a      = io && (mem_addr[2:0] == 3'd0);
      logic is_b      = io && (mem_addr[2:0] == 3'd4);
      logic a_read    = rdy && is_a && !mem_rw;
      int   depth_now = fifo_q.size();
      logic popped;
      exp_tx_valid = (depth_now != 0);
      exp_tx_data  = 8'h00;
      if (depth_now != 0) exp_tx_data = fifo_q[0];
      exp_full     = (depth_now >= FIFO_DEPTH - 2);
      exp_rx_ready = a_read && !last_a_read && rx_valid;
      popped       = exp_tx_valid && tx_ready;
      if (popped) void'(fifo_q.pop_front());
      if (rdy) begin
         if (!io) begin
            if (mem_rw) ram_m[idx] = mem_dout;
            else exp_din = ram_m.exists(idx) ? ram_m[idx] : 8'hxx;
         end else if (is_a && mem_rw) begin
            if (depth_now == FIFO_DEPTH && !popped) exp_ovf = 1'b1;
            else fifo_q.push_back(mem_dout);
         end else if (is_b && mem_rw) begin
            exp_halt = 1'b1;
         end else if (is_a) begin
            if (!last_a_read) exp_din = rx_valid ? rx_data : 8'h00;
         end else if (is_b) begin
            exp_din = depth_now[7:0];
         end else if (!mem_rw) begin
            exp_din = 8'h00;
         end
         last_a_read = a_read;
      end
   endfunction

   // Drives one bus cycle starting at a falling edge; returns at the next falling edge.
   task automatic bus_cycle(input logic r, input logic [31:0] a, input logic [7:0] d, input logic w);
      rdy = r; mem_addr = a; mem_dout = d; mem_rw = w;
      #1;
      obs_rx_ready = rx_ready;
      obs_tx_valid = tx_valid;
      obs_tx_data  = tx_data;
      obs_full     = io_buffer_full;
      model_step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b0; rdy = 1'b0; mem_addr = '0; mem_dout = '0; mem_rw = 1'b0;
      tx_ready = 1'b0; rx_data = '0; rx_valid = 1'b0;
      model_reset();
      repeat (2) @(negedge clk);
      n_checks++; if (mem_din !== 8'h00) begin n_fail++; $display("FAIL reset_mem_din: got %h want 00", mem_din); end
      n_checks++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_tx_valid: got %b want 0", tx_valid); end
      n_checks++; if (io_buffer_full !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %b want 0", io_buffer_full); end
      n_checks++; if (io_overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %b want 0", io_overflow); end
      n_checks++; if (sim_halt !== 1'b0) begin n_fail++; $display("FAIL reset_halt: got %b want 0", sim_halt); end
      n_checks++; if (rx_ready !== 1'b0) begin n_fail++; $display("FAIL reset_rx_ready: got %b want 0", rx_ready); end
      rst = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_ram_roundtrip();
      logic [16:0] addrs [$];
      logic [7:0]  fixed [4] = '{8'h12, 8'h34, 8'h56, 8'h78};
      for (int i = 0; i < 4; i++) begin
         addrs.push_back(17'(17'h100 + i));
         bus_cycle(1'b1, 32'(17'h100 + i), fixed[i], 1'b1);
      end
      for (int i = 0; i < 12; i++) begin
         logic [31:0] r  = $urandom();
         logic [16:0] ix = 17'($urandom_range(17'h400, 17'h1FFFF));
         addrs.push_back(ix);
         bus_cycle(1'b1, {r[31:18], 1'b0, ix}, 8'($urandom()), 1'b1);
      end
      foreach (addrs[k]) begin
         bus_cycle(1'b1, {15'h0, addrs[k]}, 8'h00, 1'b0);
         n_checks++;
         if (mem_din !== exp_din) begin
            n_fail++; $display("FAIL ram_read[%0h]: got %h want %h", addrs[k], mem_din, exp_din);
         end
         if (k < 4) begin
            n_checks++;
            if (mem_din !== fixed[k]) begin
               n_fail++; $display("FAIL ram_fixed[%0h]: got %h want %h", addrs[k], mem_din, fixed[k]);
            end
         end
      end
   endtask

   task automatic drain_and_check(input string tag, input int cycles);
      tx_ready = 1'b1;
      for (int i = 0; i < cycles; i++) begin
         bus_cycle(1'b0, 32'h0, 8'h00, 1'b0);
         n_checks++;
         if (obs_tx_valid !== exp_tx_valid || (exp_tx_valid && obs_tx_data !== exp_tx_data)) begin
            n_fail++;
            $display("FAIL %s_drain[%0d]: got valid=%b data=%h want valid=%b data=%h",
                     tag, i, obs_tx_valid, obs_tx_data, exp_tx_valid, exp_tx_data);
         end
      end
      tx_ready = 1'b0;
   endtask

   task automatic test_tx_drain();
      tx_ready = 1'b0;
      for (int i = 0; i < 6; i++) bus_cycle(1'b1, IO_A, 8'(8'h41 + i), 1'b1);
      n_checks++;
      if (io_buffer_full !== 1'b1) begin n_fail++; $display("FAIL tx_full_at_6: got %b want 1", io_buffer_full); end
      bus_cycle(1'b1, IO_B, 8'h00, 1'b0);
      n_checks++;
      if (mem_din !== exp_din || exp_din !== 8'd6) begin
         n_fail++; $display("FAIL tx_count_6: got %h want %h (model %h)", mem_din, 8'd6, exp_din);
      end
      drain_and_check("tx", 7);
      n_checks++;
      if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL tx_empty_after: got %b want 0", tx_valid); end
      n_checks++;
      if (mem_din !== 8'd6) begin n_fail++; $display("FAIL tx_din_held_rdy0: got %h want 06", mem_din); end
   endtask

   task automatic test_overflow();
      tx_ready = 1'b0;
      for (int i = 0; i < 9; i++) begin
         bus_cycle(1'b1, IO_A, 8'($urandom()), 1'b1);
         if (i >= 7) begin
            n_checks++;
            if (io_overflow !== exp_ovf) begin
               n_fail++; $display("FAIL ovf_after_write%0d: got %b want %b", i + 1, io_overflow, exp_ovf);
            end
         end
      end
      bus_cycle(1'b1, IO_B, 8'h00, 1'b0);
      n_checks++;
      if (mem_din !== 8'd8) begin n_fail++; $display("FAIL ovf_count_8: got %h want 08", mem_din); end
      tx_ready = 1'b1;
      bus_cycle(1'b1, IO_A, 8'hA5, 1'b1);
      tx_ready = 1'b0;
      bus_cycle(1'b1, IO_B, 8'h00, 1'b0);
      n_checks++;
      if (mem_din !== exp_din || exp_din !== 8'd8) begin
         n_fail++; $display("FAIL ovf_push_pop_full: got %h want 08 (model %h)", mem_din, exp_din);
      end
      n_checks++;
      if (io_overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %b want 1", io_overflow); end
      drain_and_check("ovf", 9);
   endtask

   task automatic test_rx_pop();
      int hits = 0;
      rx_valid = 1'b1; rx_data = 8'h5A;
      for (int i = 0; i < 3; i++) begin
         bus_cycle(1'b1, IO_A, 8'h00, 1'b0);
         if (obs_rx_ready === 1'b1) hits++;
         n_checks++;
         if (obs_rx_ready !== exp_rx_ready || mem_din !== exp_din) begin
            n_fail++; $display("FAIL rx_held[%0d]: got rdy=%b din=%h want rdy=%b din=%h",
                               i, obs_rx_ready, mem_din, exp_rx_ready, exp_din);
         end
      end
      n_checks++;
      if (hits != 1 || mem_din !== 8'h5A) begin
         n_fail++; $display("FAIL rx_pop_once: got %0d pops din=%h want 1 pop din=5a", hits, mem_din);
      end
      bus_cycle(1'b1, 32'h100, 8'h00, 1'b0);
      rx_valid = 1'b0;
      bus_cycle(1'b1, IO_A, 8'h00, 1'b0);
      n_checks++;
      if (mem_din !== 8'h00 || obs_rx_ready !== 1'b0) begin
         n_fail++; $display("FAIL rx_empty: got din=%h rdy=%b want din=00 rdy=0", mem_din, obs_rx_ready);
      end
      for (int i = 0; i < 40; i++) begin
         int kind = $urandom_range(0, 5);
         rx_valid = 1'($urandom_range(0, 1));
         rx_data  = 8'($urandom());
         case (kind)
            0, 1, 2: bus_cycle(1'b1, IO_A, 8'h00, 1'b0);
            3:       bus_cycle(1'b1, 32'h100, 8'h00, 1'b0);
            4:       bus_cycle(1'b0, IO_A, 8'h00, 1'b0);
            default: bus_cycle(1'b1, IO_B, 8'h00, 1'b0);
         endcase
         n_checks++;
         if (obs_rx_ready !== exp_rx_ready || mem_din !== exp_din) begin
            n_fail++; $display("FAIL rx_rand[%0d] kind %0d: got rdy=%b din=%h want rdy=%b din=%h",
                               i, kind, obs_rx_ready, mem_din, exp_rx_ready, exp_din);
         end
      end
      rx_valid = 1'b0;
   endtask

   task automatic test_rdy_pause();
      bus_cycle(1'b1, 32'h200, 8'hC3, 1'b1);
      bus_cycle(1'b1, 32'h200, 8'h00, 1'b0);
      bus_cycle(1'b0, 32'h200, 8'h3C, 1'b1);
      n_checks++;
      if (mem_din !== 8'hC3) begin n_fail++; $display("FAIL pause_din_held: got %h want c3", mem_din); end
      bus_cycle(1'b0, 32'h100, 8'h00, 1'b0);
      bus_cycle(1'b1, 32'h200, 8'h00, 1'b0);
      n_checks++;
      if (mem_din !== exp_din || exp_din !== 8'hC3) begin
         n_fail++; $display("FAIL pause_no_write: got %h want c3 (model %h)", mem_din, exp_din);
      end
      bus_cycle(1'b1, 32'h200, 8'h3C, 1'b1);
      bus_cycle(1'b1, 32'h200, 8'h00, 1'b0);
      n_checks++;
      if (mem_din !== 8'h3C) begin n_fail++; $display("FAIL resume_write: got %h want 3c", mem_din); end
   endtask

   task automatic test_async_reset();
      tx_ready = 1'b0;
      bus_cycle(1'b1, 32'h300, 8'h99, 1'b1);
      for (int i = 0; i < 3; i++) bus_cycle(1'b1, IO_A, 8'(8'h60 + i), 1'b1);
      bus_cycle(1'b1, IO_B, 8'h00, 1'b1);
      bus_cycle(1'b1, 32'h300, 8'h00, 1'b0);
      n_checks++;
      if (tx_valid !== 1'b1 || sim_halt !== 1'b1 || mem_din !== 8'h99) begin
         n_fail++; $display("FAIL prereset_state: got valid=%b halt=%b din=%h want 1 1 99", tx_valid, sim_halt, mem_din);
      end
      #2 rst = 1'b0;
      #1;
      n_checks++;
      if (tx_valid !== 1'b0 || mem_din !== 8'h00 || io_overflow !== 1'b0 || sim_halt !== 1'b0 || io_buffer_full !== 1'b0) begin
         n_fail++;
         $display("FAIL async_reset: got valid=%b din=%h ovf=%b halt=%b full=%b want all zero",
                  tx_valid, mem_din, io_overflow, sim_halt, io_buffer_full);
      end
      rdy = 1'b1; mem_addr = 32'h300; mem_dout = 8'h11; mem_rw = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      model_reset();
      bus_cycle(1'b1, IO_B, 8'h00, 1'b1);
      n_checks++;
      if (sim_halt !== 1'b1) begin n_fail++; $display("FAIL halt_after_reset: got %b want 1", sim_halt); end
      bus_cycle(1'b1, 32'h300, 8'h00, 1'b0);
      n_checks++;
      if (mem_din !== exp_din || exp_din !== 8'h99) begin
         n_fail++; $display("FAIL no_write_in_reset: got %h want 99 (model %h)", mem_din, exp_din);
      end
      n_checks++;
      if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL fifo_discarded: got %b want 0", tx_valid); end
   endtask

   initial begin
      test_reset();
      test_ram_roundtrip();
      test_tx_drain();
      test_overflow();
      test_rx_pop();
      test_rdy_pause();
      test_async_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1);
   end

endmodule
